// File: rtl/mul32_seq_ctrl.sv
// Iterative 32x32 unsigned multiply sequencer driving one external 8x8 multiplier.
// Optional signed correction step enabled by defining MUL32_SEQ_SIGNED_EN.
module mul32_seq_ctrl #(
  parameter int MUL8_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef MUL32_SEQ_SIGNED_EN
  input  logic        signed_mode,
`endif
  output logic        busy,
  output logic        done,
  output logic [63:0] product,
  output logic [7:0]  m8_a,
  output logic [7:0]  m8_b,
  input  logic [15:0] m8_p
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] DRAIN = 3'd2;
  localparam logic [2:0] FIN   = 3'd3;
`ifdef MUL32_SEQ_SIGNED_EN
  localparam logic [2:0] CORR  = 3'd4;
  localparam logic [2:0] POST  = CORR;
`else
  localparam logic [2:0] POST  = FIN;
`endif
  localparam logic [1:0] LAT_M1 = 2'((MUL8_LAT > 0) ? (MUL8_LAT - 1) : 0);

  logic [2:0]  r_state;
  logic [2:0]  w_nxt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [3:0]  r_idx;
  logic [1:0]  r_dcnt;
  logic [63:0] r_acc;
  logic [63:0] r_product;
  logic [1:0]  w_i;
  logic [1:0]  w_j;
  logic [2:0]  w_k;
  logic        w_issue;
  logic        w_em_vld;
  logic [2:0]  w_em_k;
  logic [63:0] w_add;
  logic [63:0] w_acc_nxt;
`ifdef MUL32_SEQ_SIGNED_EN
  logic        r_sm;
  logic [63:0] w_corr;
`endif

  // Column-major byte-pair order: all pairs of equal weight are issued together.
  always_comb begin
    w_i = 2'd0;
    w_j = 2'd0;
    case (r_idx)
      4'd0:  begin w_i = 2'd0; w_j = 2'd0; end
      4'd1:  begin w_i = 2'd0; w_j = 2'd1; end
      4'd2:  begin w_i = 2'd1; w_j = 2'd0; end
      4'd3:  begin w_i = 2'd0; w_j = 2'd2; end
      4'd4:  begin w_i = 2'd1; w_j = 2'd1; end
      4'd5:  begin w_i = 2'd2; w_j = 2'd0; end
      4'd6:  begin w_i = 2'd0; w_j = 2'd3; end
      4'd7:  begin w_i = 2'd1; w_j = 2'd2; end
      4'd8:  begin w_i = 2'd2; w_j = 2'd1; end
      4'd9:  begin w_i = 2'd3; w_j = 2'd0; end
      4'd10: begin w_i = 2'd1; w_j = 2'd3; end
      4'd11: begin w_i = 2'd2; w_j = 2'd2; end
      4'd12: begin w_i = 2'd3; w_j = 2'd1; end
      4'd13: begin w_i = 2'd2; w_j = 2'd3; end
      4'd14: begin w_i = 2'd3; w_j = 2'd2; end
      default: begin w_i = 2'd3; w_j = 2'd3; end
    endcase
  end

  assign w_k     = {1'b0, w_i} + {1'b0, w_j};
  assign w_issue = (r_state == ISSUE);
  assign m8_a    = w_issue ? r_a[{w_i, 3'b000} +: 8] : 8'd0;
  assign m8_b    = w_issue ? r_b[{w_j, 3'b000} +: 8] : 8'd0;

  // Shift amounts travel alongside the in-flight products of the external multiplier.
  generate
    if (MUL8_LAT == 0) begin : g_comb
      assign w_em_vld = w_issue;
      assign w_em_k   = w_k;
    end else begin : g_pipe
      logic       r_pv [MUL8_LAT];
      logic [2:0] r_pk [MUL8_LAT];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < MUL8_LAT; s++) begin
            r_pv[s] <= 1'b0;
            r_pk[s] <= 3'd0;
          end
        end else begin
          r_pv[0] <= w_issue;
          r_pk[0] <= w_k;
          for (int s = 1; s < MUL8_LAT; s++) begin
            r_pv[s] <= r_pv[s-1];
            r_pk[s] <= r_pk[s-1];
          end
        end
      end
      assign w_em_vld = r_pv[MUL8_LAT-1];
      assign w_em_k   = r_pk[MUL8_LAT-1];
    end
  endgenerate

  assign w_add     = w_em_vld ? ({48'd0, m8_p} << {w_em_k, 3'b000}) : 64'd0;
  assign w_acc_nxt = r_acc + w_add;

`ifdef MUL32_SEQ_SIGNED_EN
  assign w_corr = ((r_sm && r_a[31]) ? {r_b, 32'd0} : 64'd0)
                + ((r_sm && r_b[31]) ? {r_a, 32'd0} : 64'd0);
`endif

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:  if (start) w_nxt = ISSUE;
      ISSUE: if (r_idx == 4'd15) w_nxt = (MUL8_LAT > 0) ? DRAIN : POST;
      DRAIN: if (r_dcnt == LAT_M1) w_nxt = POST;
`ifdef MUL32_SEQ_SIGNED_EN
      CORR:  w_nxt = FIN;
`endif
      FIN:   w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_idx     <= 4'd0;
      r_dcnt    <= 2'd0;
      r_acc     <= 64'd0;
      r_product <= 64'd0;
`ifdef MUL32_SEQ_SIGNED_EN
      r_sm      <= 1'b0;
`endif
    end else begin
      r_state <= w_nxt;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a    <= a;
            r_b    <= b;
            r_acc  <= 64'd0;
            r_idx  <= 4'd0;
            r_dcnt <= 2'd0;
`ifdef MUL32_SEQ_SIGNED_EN
            r_sm   <= signed_mode;
`endif
          end
        end
        ISSUE: begin
          r_acc <= w_acc_nxt;
          r_idx <= r_idx + 4'd1;
        end
        DRAIN: begin
          r_acc  <= w_acc_nxt;
          r_dcnt <= r_dcnt + 2'd1;
        end
        default: ;
      endcase
`ifdef MUL32_SEQ_SIGNED_EN
      if (r_state == CORR) r_product <= r_acc - w_corr;
`else
      // The final product lands on the same edge as the last accumulation.
      if (w_nxt == FIN && r_state != FIN) r_product <= w_acc_nxt;
`endif
    end
  end

`ifdef MUL32_SEQ_SIGNED_EN
  assign busy = (r_state == ISSUE) || (r_state == DRAIN) || (r_state == CORR);
`else
  assign busy = (r_state == ISSUE) || (r_state == DRAIN);
`endif
  assign done    = (r_state == FIN);
  assign product = r_product;

endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// Bench for mul32_seq_ctrl: one combinational-multiplier instance and one with a 2-cycle multiplier.
module tb_mul32_seq_ctrl;

`ifdef MUL32_SEQ_SIGNED_EN
  localparam int E = 1;
`else
  localparam int E = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        sm;
  logic        busy0, done0, busy2, done2;
  logic [63:0] product0, product2;
  logic [7:0]  m8a0, m8b0, m8a2, m8b2;
  logic [15:0] m8p0, m8p2, d1, d2;

  int checks = 0;
  int passed = 0;
  int ei [16];
  int ej [16];

  always #5 clk = ~clk;

  assign m8p0 = 16'(m8a0) * 16'(m8b0);
  always @(posedge clk) begin
    d1 <= 16'(m8a2) * 16'(m8b2);
    d2 <= d1;
  end
  assign m8p2 = d2;

  mul32_seq_ctrl #(.MUL8_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
`ifdef MUL32_SEQ_SIGNED_EN
    .signed_mode(sm),
`endif
    .busy(busy0), .done(done0), .product(product0),
    .m8_a(m8a0), .m8_b(m8b0), .m8_p(m8p0)
  );

  mul32_seq_ctrl #(.MUL8_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
`ifdef MUL32_SEQ_SIGNED_EN
    .signed_mode(sm),
`endif
    .busy(busy2), .done(done2), .product(product2),
    .m8_a(m8a2), .m8_b(m8b2), .m8_p(m8p2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (s && E == 1) return 64'(sx * sy);
    return {32'd0, x} * {32'd0, y};
  endfunction

  // One full operation; optionally pulses start with zero operands in cycle pulse_c.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic ts, input int pulse_c);
    logic [63:0] exp_p;
    logic [7:0]  xa, xb;
    int nd0, nd2;
    exp_p = ref_mul(ta, tb, ts);
    nd0 = 0;
    nd2 = 0;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb; sm = ts;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; sm = ~ts;
    for (int c = 1; c <= 22 + E; c++) begin
      if (c == pulse_c) begin start = 1'b1; a = 32'd0; b = 32'd0; end
      else start = 1'b0;
      if (c <= 16) begin
        xa = 8'(ta >> (8 * ei[c-1]));
        xb = 8'(tb >> (8 * ej[c-1]));
      end else begin
        xa = 8'd0;
        xb = 8'd0;
      end
      chk("m8_a lat0", 64'(m8a0), 64'(xa));
      chk("m8_b lat0", 64'(m8b0), 64'(xb));
      chk("m8_a lat2", 64'(m8a2), 64'(xa));
      chk("m8_b lat2", 64'(m8b2), 64'(xb));
      chk("busy lat0", 64'(busy0), 64'(c <= 16 + E));
      chk("busy lat2", 64'(busy2), 64'(c <= 18 + E));
      chk("done lat0", 64'(done0), 64'(c == 17 + E));
      chk("done lat2", 64'(done2), 64'(c == 19 + E));
      if (done0) begin nd0++; chk("product lat0", product0, exp_p); end
      if (done2) begin nd2++; chk("product lat2", product2, exp_p); end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("done count lat0", 64'(nd0), 64'd1);
    chk("done count lat2", 64'(nd2), 64'd1);
    chk("product hold lat0", product0, exp_p);
    chk("product hold lat2", product2, exp_p);
  endtask

  initial begin
    int n;
    n = 0;
    for (int k = 0; k <= 6; k++)
      for (int i = 0; i <= 3; i++)
        if (k - i >= 0 && k - i <= 3) begin
          ei[n] = i;
          ej[n] = k - i;
          n++;
        end

    rst = 1'b1; start = 1'b0; a = 32'd0; b = 32'd0; sm = 1'b0;
    #1;
    chk("reset busy", 64'(busy0 | busy2), 64'd0);
    chk("reset done", 64'(done0 | done2), 64'd0);
    chk("reset product lat0", product0, 64'd0);
    chk("reset product lat2", product2, 64'd0);
    chk("reset m8 lat0", 64'({m8a0, m8b0}), 64'd0);
    chk("reset m8 lat2", 64'({m8a2, m8b2}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, -1);
    run_op(32'h44332211, 32'h88776655, 1'b0, -1);
    run_op(32'h00010000, 32'h00010000, 1'b0, -1);
    run_op(32'h80000000, 32'h00000002, 1'b0, 5);
    run_op(32'h00000000, 32'hDEADBEEF, 1'b0, -1);
    run_op(32'h12345678, 32'h00000000, 1'b0, -1);
    for (int r = 0; r < 5; r++) run_op($urandom, $urandom, 1'b0, -1);

    // Abort mid-operation.
    @(negedge clk);
    start = 1'b1; a = 32'hCAFEF00D; b = 32'h0BADBEEF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("abort busy", 64'(busy0 | busy2), 64'd0);
    chk("abort done", 64'(done0 | done2), 64'd0);
    chk("abort product lat0", product0, 64'd0);
    chk("abort product lat2", product2, 64'd0);
    chk("abort m8 lat0", 64'({m8a0, m8b0}), 64'd0);
    chk("abort m8 lat2", 64'({m8a2, m8b2}), 64'd0);
    @(posedge clk); #1;
    chk("abort no done", 64'(done0 | done2), 64'd0);
    @(negedge clk); rst = 1'b0;
    run_op(32'd3, 32'd5, 1'b0, -1);

`ifdef MUL32_SEQ_SIGNED_EN
    run_op(32'hFFFFFFFF, 32'h00000002, 1'b1, -1);
    run_op(32'hFFFFFFFF, 32'h00000002, 1'b0, -1);
    for (int r = 0; r < 4; r++) run_op($urandom, $urandom, 1'b1, -1);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mul32_seq_ctrl.md
Name: mul32_seq_ctrl

Overview:
- Sequencer for an iterative 32x32 multiply built around one shared 8x8 multiplier instance (mul8_top_yjy class), which sits outside this block.
- Latches two 32-bit operands on a start strobe and issues the 16 byte-pair partial products in column-major order.
- Accumulates each returned 16-bit product into a 64-bit result at weight 8*(i+j).
- Gives the team a small-area alternative to the parallel column stages (mulMiddle_*) of the 32-bit multiplier.

Parameters:
MUL8_LAT, 0, pipeline latency of the external 8x8 multiplier in cycles; legal values 0..3 (0 = combinational, product returned in the same cycle).

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  32  multiplicand; latched when start is accepted
b  input  32  multiplier; latched when start is accepted
busy  output  1  high from the cycle after acceptance until the cycle before done
done  output  1  one-cycle pulse; product is valid in this cycle
product  output  64  result register; holds its value until the next completion
m8_a  output  8  byte to the external 8x8 multiplier
m8_b  output  8  byte to the external 8x8 multiplier
m8_p  input  16  unsigned product returned by the external multiplier MUL8_LAT cycles after issue

Behaviour:
- Reset (asynchronous, active-high) values:
  - state IDLE; busy 0, done 0, product 0, m8_a 0, m8_b 0.
  - Internal accumulator 0; issue index 0; latency pipeline valid bits cleared.
- States: IDLE, ISSUE, DRAIN, FIN.
- IDLE:
  - start=1 at an edge: latch a and b, clear the accumulator, set index=0, go to ISSUE.
  - start=0: stay in IDLE.
- ISSUE (16 cycles, index 0..15):
  - Each cycle drives m8_a=a[8i+7:8i] and m8_b=b[8j+7:8j].
  - Schedule: column k=0..6; within a column, i ascends from max(0,k-3) to min(3,k), with j=k-i.
  - Resulting (i,j) sequence: (0,0),(0,1),(1,0),(0,2),(1,1),(2,0),(0,3),(1,2),(2,1),(3,0),(1,3),(2,2),(3,1),(2,3),(3,2),(3,3).
  - Exit after index 15: go to DRAIN if MUL8_LAT>0, otherwise to FIN.
- Shift pipeline:
  - A MUL8_LAT-deep pipeline carries a valid bit and the shift amount k (3 bits) alongside each issue.
  - When an entry emerges: acc <= acc + (zero-extended m8_p << 8k). This is 64-bit modulo arithmetic; no overflow is possible for unsigned inputs.
  - With MUL8_LAT=0, m8_p is accumulated in the same cycle it is issued.
- DRAIN:
  - Lasts MUL8_LAT cycles; m8_a and m8_b are driven 0.
  - Pending products are still accumulated.
  - Then go to FIN.
- FIN (1 cycle):
  - done=1, busy=0.
  - product is loaded with the final accumulator value at the edge entering FIN, so it is valid while done=1.
  - Next state IDLE. A start sampled in FIN is ignored.
- Timing: the acceptance edge ends cycle 0. busy is high in cycles 1..16+MUL8_LAT. done is high in cycle 17+MUL8_LAT.
- m8_a and m8_b are 0 in every state except ISSUE.
- Boundary cases:
  - start while busy or in FIN: ignored; latched operands are unchanged.
  - start held high continuously: a new operation is accepted on each return to IDLE.
  - a or b equal to 0: the full sequence still runs; product=0.
  - rst mid-operation: abort immediately to reset values; no done pulse; product cleared to 0.

Optional Feature:
MUL32_SEQ_SIGNED_EN
- Defined:
  - Adds input signed_mode (1 bit), latched together with a and b.
  - FIN is preceded by a one-cycle CORR state, which adds 1 to busy-to-done latency.
  - CORR applies only when signed_mode=1 and subtracts modulo 2^64:
    - (b<<32) if a[31]=1;
    - (a<<32) if b[31]=1.
  - The result is the two's-complement signed product.
  - With signed_mode=0, CORR is still spent but makes no change.
- Undefined: the port and the CORR state are absent; operation is unsigned only.

Test Plan:
- MUL8_LAT=0, a=0xFFFFFFFF, b=0xFFFFFFFF -> done pulses in cycle 17 (cycle 18 with the macro); product=0xFFFFFFFE00000001; busy high exactly 16 cycles.
- a=0x44332211, b=0x88776655 -> (m8_a,m8_b) trace on the first three issue cycles is (0x11,0x55),(0x11,0x66),(0x22,0x55); the last issue cycle is (0x44,0x88).
- MUL8_LAT=2 with a behavioural delayed multiplier, a=0x00010000, b=0x00010000 -> product=0x0000000100000000; done in cycle 19.
- start pulsed again in cycle 5 with a=0, b=0 during an 0x80000000*0x00000002 operation -> second request ignored; product=0x0000000100000000; exactly one done pulse.
- rst asserted in cycle 8 of an operation -> all outputs 0 immediately; no done. Restart with 3*5 -> product=0x000000000000000F.
- MUL32_SEQ_SIGNED_EN, signed_mode=1, a=0xFFFFFFFF, b=0x00000002 -> product=0xFFFFFFFFFFFFFFFE. Same operands with signed_mode=0 -> product=0x00000001FFFFFFFE.
